universal_shift_reg: RTL
========================

Name: universal_shift_reg

Overview:
- Parametrised universal shift register, the successor to the fixed 4-bit left/right shifter.
- Supports configurable width, eight operation modes, and per-side serial inputs.
- Adds a multi-step "burst" shift: one command shifts N times, with busy/done handshake.
- Sits in the sequential-logic lab set as a reusable datapath element for serializers and barrel-shift emulation.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- CNT_W, 4, width of burst step count (max burst = 2^CNT_W-1).
- RST_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  operation enable (single ops in IDLE; stall in RUN).
- mode  input  3  operation select (see Behaviour).
- sl_in  input  1  serial input entering at bit 0 on shift left.
- sr_in  input  1  serial input entering at bit WIDTH-1 on shift right.
- d_in  input  WIDTH  parallel load data.
- start  input  1  burst request (sampled in IDLE only).
- amount  input  CNT_W  burst step count.
- q  output  WIDTH  register contents.
- so_msb  output  1  combinational q[WIDTH-1].
- so_lsb  output  1  combinational q[0].
- busy  output  1  high while burst in RUN.
- done  output  1  one-cycle burst completion pulse.

Behaviour:
- Reset (rst=1, any time, asynchronous): q=RST_VAL, busy=0, done=0, state=IDLE, internal count=0, latched mode=000. A burst in progress is abandoned with no completion pulse.
- Mode encoding (one step):
  - 000 hold.
  - 001 shift left: q <= {q[W-2:0], sl_in}.
  - 010 shift right: q <= {sr_in, q[W-1:1]}.
  - 011 rotate left: {q[W-2:0], q[W-1]}.
  - 100 rotate right: {q[0], q[W-1:1]}.
  - 101 parallel load d_in.
  - 110 arithmetic shift right: {q[W-1], q[W-1:1]}.
  - 111 clear to 0.
- State IDLE:
  - start=0, en=1: apply mode once at this edge; q updates 1 cycle after sampling.
  - en=0 and start=0: q holds.
  - start=1 (regardless of en): latch mode into lmode and amount into count; no shift this edge.
    - amount=0: stay IDLE; done=1 on the next cycle only.
    - amount≠0: go RUN; busy=1 from the next cycle.
- State RUN:
  - Each edge with en=1: apply lmode once, count--. sl_in, sr_in and d_in are sampled live each step.
  - en=0: stall; q and count hold; busy stays 1.
  - Step with count==1: final shift; go IDLE; busy=0 and done=1 in the same cycle q shows the final value. done drops after 1 cycle.
  - mode, start and amount are ignored in RUN.
  - start=1 in the IDLE cycle right after done is accepted, giving back-to-back bursts.
- Timing: a burst of N steps with en held high has busy high for exactly N cycles, and start-to-done is N+1 edges.
- so_msb and so_lsb are purely combinational from q. No other combinational path from inputs to outputs.
- All state updates use nonblocking assignment in a single clocked process. Next-state/mode decode is fully specified, with no latches.

Test Plan:
- WIDTH=8, RST_VAL=8'hA5; pulse rst mid-cycle, no clock edge -> q=A5, busy=0, done=0 immediately.
- load d_in=8'h81 (mode 101), then mode 001 sl_in=1 for 1 cycle -> q=03; then mode 010 sr_in=0 -> q=01; then mode 110 with q=80 -> q=C0.
- q=8'h96, start=1, mode=011, amount=3, en=1 -> busy high 3 cycles, q sequence 2D,5A,B4; done=1 with q=B4 one cycle only.
- Same burst with en=0 for 2 cycles after the first step -> q holds 2D, busy stays 1, completion delayed 2 cycles, final q=B4.
- start=1, amount=0 -> no shift, busy never high, done=1 for exactly 1 cycle; changing mode/start during a RUN has no effect.
- Burst amount=5 mode 001, assert rst after step 2 -> q=RST_VAL, busy=0, no done pulse; next start runs normally.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: eight single-step modes plus a
// counted burst that repeats a latched mode N times with busy/done handshake.
//
// state | meaning
// IDLE  | single ops on en, accepts burst start
// RUN   | burst active, one lmode step per enabled edge
module universal_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sl_in,
  input  logic             sr_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [2:0]       lmode, lmode_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    case (m)
      3'b000:  r = cur;
      3'b001:  r = {cur[WIDTH-2:0], sl};
      3'b010:  r = {sr, cur[WIDTH-1:1]};
      3'b011:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b100:  r = {cur[0], cur[WIDTH-1:1]};
      3'b101:  r = d;
      3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= RST_VAL;
      count <= '0;
      lmode <= 3'b000;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      count <= count_nxt;
      lmode <= lmode_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    count_nxt = count;
    lmode_nxt = lmode;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // start wins over en; a zero-length burst completes without running
        if (start) begin
          lmode_nxt = mode;
          count_nxt = amount;
          if (amount == '0) done_nxt = 1'b1;
          else              state_nxt = RUN;
        end else if (en) begin
          q_nxt = shift_step(mode, q, sl_in, sr_in, d_in);
        end
      end
      RUN: begin
        if (en) begin
          q_nxt     = shift_step(lmode, q, sl_in, sr_in, d_in);
          count_nxt = count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    so_msb = q[WIDTH-1];
    so_lsb = q[0];
  end

endmodule
